biu_arb_n: RTL and testbench
============================

Name: biu_arb_n

Overview:
- Parametrised N-requestor bus-interface arbiter and transaction sequencer for the picoJava memory port.
- Successor to the two-port fixed-priority ICU/DCU arbiter.
- Selects one requestor with round-robin priority, drives pj_tv/pj_type/pj_size/pj_ale, and counts a per-request number of acknowledge beats. Beats are set by the requestor, not decoded from type.
- Routes pj_ack back only to the owning requestor. Sits between the cache units and the external pj bus.

Parameters:
NUM_REQ, 2, number of requestors (2..8); index 0 is highest priority after reset
TYPE_W, 4, width of per-requestor transaction type
SIZE_W, 2, width of per-requestor transaction size
BEAT_W, 3, width of per-requestor beat count (max beats 2^BEAT_W-1)
TIMEOUT, 255, watchdog limit in cycles (used only with BIU_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  one clock; reset is synchronous and active-high
req  in  NUM_REQ  request per requestor, held until first ack
req_type  in  NUM_REQ*TYPE_W  flattened types, requestor i at [i*TYPE_W +: TYPE_W]
req_size  in  NUM_REQ*SIZE_W  flattened sizes
req_beats  in  NUM_REQ*BEAT_W  acks expected for the request; 0 treated as 1
pj_ack  in  2  [0] normal ack, [1] error ack
pj_tv  out  1  transfer valid
pj_type  out  TYPE_W  muxed type
pj_size  out  SIZE_W  muxed size
pj_ale  out  1  address latch enable, active low
grant  out  NUM_REQ  one-hot owner
req_ack  out  NUM_REQ*2  pj_ack routed to owner, zero elsewhere
busy  out  1  state != IDLE

Behaviour:
- States (one-hot): IDLE, REQ_ACTIVE, DATA. Reset forces IDLE, rr pointer=0, beat counter=0, latched grant/type/size=0.
- Outputs during reset and after it: pj_tv=0 if req=0, pj_ale=1, grant=0, req_ack=0, busy=0.
- Winner: the first requestor asserting req, scanning from rr pointer upward with wrap modulo NUM_REQ.

IDLE:
- Winner selection, grant, pj_type and pj_size are combinational from req.
- pj_tv = |req. pj_ale = ~pj_tv.
- If |req: go to REQ_ACTIVE next cycle.
- Latch grant, type, size, and beats (0→1).
- rr pointer = (winner+1) mod NUM_REQ.
- pj_ack in IDLE is ignored; req_ack=0.

REQ_ACTIVE:
- pj_tv=1, pj_ale=1. Outputs come from latched values.
- Error ack (pj_ack[1], including 2'b11) → IDLE.
- Normal ack with beats==1 → IDLE.
- Normal ack with beats>1 → DATA, counter=beats-1.
- No ack → stay.

DATA:
- pj_tv=0.
- Error ack → IDLE.
- Normal ack: counter-=1; when counter==1 the ack → IDLE.

General rules:
- req_ack[owner] = pj_ack whenever state != IDLE; combinational, zero latency.
- Request changes after the IDLE cycle have no effect until return to IDLE.
- Simultaneous requests: only the winner is granted; losers wait. With continuous requests no requestor waits more than NUM_REQ-1 transactions.
- Back-to-back: the cycle after the final ack is IDLE and can launch a new pj_tv immediately.
- Reset mid-transaction: IDLE next cycle, no req_ack, pointer=0.

Optional Feature:
- Macro BIU_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in REQ_ACTIVE/DATA. It clears on any pj_ack and on entry to either state.
  - When the count reaches TIMEOUT with no ack, the FSM returns to IDLE next cycle.
  - req_ack[owner] = 2'b10 (synthetic error) for exactly that cycle.
  - Output timeout_err (1 bit) pulses 1 that cycle.
- Undefined: no counter; the FSM waits indefinitely; the timeout_err port is absent.

Test Plan:
- NUM_REQ=2, req=2'b11, beats 4 and 1, pj_ack=01 every cycle after pj_tv →
  - grant 01 first, with type/size of req0, 4 req_ack pulses on requestor 0.
  - IDLE, then grant 10, 1 pulse.
  - rr pointer alternates.
- NUM_REQ=4, all req held → grant order 0,1,2,3,0, each transaction one ack.
- beats=4, error ack on beat 2 → IDLE the following cycle; requestor sees 01,10; no further beats counted.
- beats=0 → treated as 1; single ack returns to IDLE; pj_ale low only in the IDLE launch cycle.
- reset asserted in DATA with counter=2 → next cycle busy=0, grant=0, pj_ale=1; a later req from index 1 still loses to simultaneous index 0.
- With BIU_ARB_TIMEOUT_EN, TIMEOUT=8, no ack →
  - timeout_err and req_ack=10 on cycle 8 after entering REQ_ACTIVE, then IDLE.
  - An ack on cycle 5 restarts the count.

Source files
------------

// File: rtl/biu_arb_n_if.sv
// biu_arb_n_if: requestor/pj-bus signal bundle for the biu_arb_n arbiter.
// The master modport is the arbiter's view; the slave modport is the view of
// whatever sits around it (cache units plus external pj bus, or a bench).
// When BIU_ARB_TIMEOUT_EN is defined the bundle also carries timeout_err.
interface biu_arb_n_if #(
    parameter int NUM_REQ = 2,
    parameter int TYPE_W  = 4,
    parameter int SIZE_W  = 2,
    parameter int BEAT_W  = 3
);
    // Requestor side
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*TYPE_W-1:0] req_type;
    logic [NUM_REQ*SIZE_W-1:0] req_size;
    logic [NUM_REQ*BEAT_W-1:0] req_beats;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ*2-1:0]      req_ack;

    // External pj bus side
    logic [1:0]                pj_ack;
    logic                      pj_tv;
    logic [TYPE_W-1:0]         pj_type;
    logic [SIZE_W-1:0]         pj_size;
    logic                      pj_ale;

    // Status
    logic                      busy;
`ifdef BIU_ARB_TIMEOUT_EN
    logic                      timeout_err;
`endif

`ifdef BIU_ARB_TIMEOUT_EN
    modport master (
        input  req, req_type, req_size, req_beats, pj_ack,
        output pj_tv, pj_type, pj_size, pj_ale, grant, req_ack, busy, timeout_err
    );
    modport slave (
        output req, req_type, req_size, req_beats, pj_ack,
        input  pj_tv, pj_type, pj_size, pj_ale, grant, req_ack, busy, timeout_err
    );
`else
    modport master (
        input  req, req_type, req_size, req_beats, pj_ack,
        output pj_tv, pj_type, pj_size, pj_ale, grant, req_ack, busy
    );
    modport slave (
        output req, req_type, req_size, req_beats, pj_ack,
        input  pj_tv, pj_type, pj_size, pj_ale, grant, req_ack, busy
    );
`endif
endinterface

// File: rtl/biu_arb_n.sv
// biu_arb_n: N-requestor round-robin arbiter and transaction sequencer for
// the picoJava memory port. A winner is chosen combinationally while IDLE so
// pj_tv can launch in the same cycle a request appears; grant/type/size and
// the beat count are then latched and held until the last (or an error) ack.
// Optional feature macro: BIU_ARB_TIMEOUT_EN adds a watchdog that aborts a
// transaction with a synthetic error ack after TIMEOUT ack-less cycles and
// pulses timeout_err.
module biu_arb_n #(
    parameter int NUM_REQ = 2,
    parameter int TYPE_W  = 4,
    parameter int SIZE_W  = 2,
    parameter int BEAT_W  = 3,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    biu_arb_n_if.master bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_cfg_check
        $error("biu_arb_n: NUM_REQ must be 2..8 and TIMEOUT must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE       = 3'b001,
        REQ_ACTIVE = 3'b010,
        DATA       = 3'b100
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_q, rr_d;
    logic [BEAT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [TYPE_W-1:0]   type_q, type_d;
    logic [SIZE_W-1:0]   size_q, size_d;

    logic [PTR_W-1:0]    win;
    logic [NUM_REQ-1:0]  win_oh;
    logic                any_req;
    logic [BEAT_W-1:0]   win_beats;
    logic                ack_err;
    logic                ack_ok;
    logic                tmo_fire;

    logic                tv_w;
    logic                ale_w;
    logic [TYPE_W-1:0]   ptype_w;
    logic [SIZE_W-1:0]   psize_w;
    logic [NUM_REQ-1:0]  grant_w;
    logic [NUM_REQ*2-1:0] rack_w;
    logic                busy_w;
    logic [1:0]          ack_route;

`ifdef BIU_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]    tmo_q, tmo_d;
`endif

    // First requestor found scanning upward from the rr pointer, with wrap.
    function automatic logic [PTR_W-1:0] pick_winner(
        input logic [NUM_REQ-1:0] r,
        input logic [PTR_W-1:0]   ptr
    );
        logic [PTR_W-1:0] w;
        logic             found;
        int               idx;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && r[PTR_W'(idx)]) begin
                w     = PTR_W'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    // Arbitration and ack decode shared by the next-state and output logic.
    always_comb begin
        any_req   = |bus.req;
        win       = pick_winner(bus.req, rr_q);
        win_oh    = NUM_REQ'(1) << win;
        win_beats = bus.req_beats[win*BEAT_W +: BEAT_W];
        if (win_beats == '0) begin
            win_beats = BEAT_W'(1);
        end
        ack_err   = bus.pj_ack[1];
        ack_ok    = bus.pj_ack[0] & ~bus.pj_ack[1];
`ifdef BIU_ARB_TIMEOUT_EN
        tmo_fire  = (state_q != IDLE) && (bus.pj_ack == 2'b00) &&
                    (tmo_q == TMO_W'(TIMEOUT - 1));
`else
        tmo_fire  = 1'b0;
`endif
    end

    // Next-state logic: launch from IDLE, count beats, leave on last/error ack.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        type_d  = type_q;
        size_d  = size_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = REQ_ACTIVE;
                    grant_d = win_oh;
                    type_d  = bus.req_type[win*TYPE_W +: TYPE_W];
                    size_d  = bus.req_size[win*SIZE_W +: SIZE_W];
                    cnt_d   = win_beats;
                    rr_d    = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                end
            end
            REQ_ACTIVE, DATA: begin
                if (tmo_fire || ack_err) begin
                    state_d = IDLE;
                end else if (ack_ok) begin
                    if (cnt_q == BEAT_W'(1)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef BIU_ARB_TIMEOUT_EN
    // Watchdog counts ack-less cycles; cleared on entry and on any ack.
    always_comb begin
        if (state_q == IDLE || bus.pj_ack != 2'b00 || tmo_fire) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end
`endif

    // State and latched transaction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            type_q  <= '0;
            size_q  <= '0;
`ifdef BIU_ARB_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            type_q  <= type_d;
            size_q  <= size_d;
`ifdef BIU_ARB_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Bus outputs: live mux while IDLE, latched values once a transaction runs;
    // reset masks everything to the quiet bus state.
    always_comb begin
        tv_w      = 1'b0;
        ale_w     = 1'b1;
        ptype_w   = '0;
        psize_w   = '0;
        grant_w   = '0;
        rack_w    = '0;
        busy_w    = 1'b0;
        ack_route = tmo_fire ? 2'b10 : bus.pj_ack;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    tv_w  = any_req;
                    ale_w = ~any_req;
                    if (any_req) begin
                        grant_w = win_oh;
                        ptype_w = bus.req_type[win*TYPE_W +: TYPE_W];
                        psize_w = bus.req_size[win*SIZE_W +: SIZE_W];
                    end
                end
                REQ_ACTIVE, DATA: begin
                    tv_w    = (state_q == REQ_ACTIVE);
                    grant_w = grant_q;
                    ptype_w = type_q;
                    psize_w = size_q;
                    busy_w  = 1'b1;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        rack_w[2*i +: 2] = grant_q[i] ? ack_route : 2'b00;
                    end
                end
                default: begin
                    tv_w = 1'b0;
                end
            endcase
        end
    end

    assign bus.pj_tv   = tv_w;
    assign bus.pj_ale  = ale_w;
    assign bus.pj_type = ptype_w;
    assign bus.pj_size = psize_w;
    assign bus.grant   = grant_w;
    assign bus.req_ack = rack_w;
    assign bus.busy    = busy_w;
`ifdef BIU_ARB_TIMEOUT_EN
    assign bus.timeout_err = tmo_fire && !reset;
`endif

endmodule

// File: tb/tb_biu_arb_n.sv
// tb_biu_arb_n: bench for biu_arb_n with four requestors. A directed vector
// table, a few hand-written multi-cycle sequences and a random phase are all
// checked against a transaction-level reference model kept in this file.
module tb_biu_arb_n;
    localparam int NR  = 4;
    localparam int TW  = 4;
    localparam int SW  = 2;
    localparam int BW  = 3;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    biu_arb_n_if #(.NUM_REQ(NR), .TYPE_W(TW), .SIZE_W(SW), .BEAT_W(BW)) bus ();

    biu_arb_n #(.NUM_REQ(NR), .TYPE_W(TW), .SIZE_W(SW), .BEAT_W(BW), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit         m_busy  = 1'b0;
    bit         m_first = 1'b0;
    int         m_owner = 0;
    int         m_rem   = 0;
    int         m_rr    = 0;
    int         m_wait  = 0;
    logic [TW-1:0] m_type = '0;
    logic [SW-1:0] m_size = '0;
    bit         e_fire;

    function automatic int model_win();
        for (int k = 0; k < NR; k++) begin
            if (bus.req[(m_rr + k) % NR]) return (m_rr + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_check();
        logic          e_tv, e_ale, e_busy;
        logic [NR-1:0] e_grant;
        logic [2*NR-1:0] e_rack;
        logic [TW-1:0] e_type;
        logic [SW-1:0] e_size;
        bit            cmp_ts;
        int            w;
        e_fire = 1'b0;
        cmp_ts = 1'b0;
        e_type = '0;
        e_size = '0;
        if (reset) begin
            e_tv = 0; e_ale = 1; e_grant = '0; e_rack = '0; e_busy = 0;
        end else if (!m_busy) begin
            w       = model_win();
            e_tv    = (w >= 0);
            e_ale   = !e_tv;
            e_grant = (w >= 0) ? NR'(1) << w : '0;
            e_rack  = '0;
            e_busy  = 0;
            if (w >= 0) begin
                cmp_ts = 1'b1;
                e_type = bus.req_type[w*TW +: TW];
                e_size = bus.req_size[w*SW +: SW];
            end
        end else begin
            e_tv    = m_first;
            e_ale   = 1;
            e_grant = NR'(1) << m_owner;
            e_busy  = 1;
            cmp_ts  = 1'b1;
            e_type  = m_type;
            e_size  = m_size;
            e_rack  = (2*NR)'(bus.pj_ack) << (2*m_owner);
`ifdef BIU_ARB_TIMEOUT_EN
            if (bus.pj_ack == 2'b00 && m_wait + 1 == TMO) begin
                e_fire = 1'b1;
                e_rack = (2*NR)'(2'b10) << (2*m_owner);
            end
`endif
        end
        chk("model_tv", bus.pj_tv, e_tv);
        chk("model_ale", bus.pj_ale, e_ale);
        chk("model_grant", bus.grant, e_grant);
        chk("model_req_ack", bus.req_ack, e_rack);
        chk("model_busy", bus.busy, e_busy);
        if (cmp_ts) begin
            chk("model_type", bus.pj_type, e_type);
            chk("model_size", bus.pj_size, e_size);
        end
`ifdef BIU_ARB_TIMEOUT_EN
        chk("model_timeout_err", bus.timeout_err, e_fire);
`endif
    endtask

    task automatic model_advance();
        int w;
        int b;
        if (reset) begin
            m_busy = 0; m_rr = 0; m_wait = 0;
        end else if (!m_busy) begin
            w = model_win();
            if (w >= 0) begin
                b       = int'(bus.req_beats[w*BW +: BW]);
                m_busy  = 1;
                m_first = 1;
                m_owner = w;
                m_rem   = (b == 0) ? 1 : b;
                m_type  = bus.req_type[w*TW +: TW];
                m_size  = bus.req_size[w*SW +: SW];
                m_rr    = (w + 1) % NR;
                m_wait  = 0;
            end
        end else if (e_fire || bus.pj_ack[1]) begin
            m_busy = 0;
        end else if (bus.pj_ack[0]) begin
            m_rem--;
            m_first = 0;
            m_wait  = 0;
            if (m_rem == 0) m_busy = 0;
        end else begin
            m_wait++;
        end
    endtask

    // Inputs change #1 after posedge; outputs are checked on negedge.
    task automatic half();
        @(negedge clk);
    endtask

    task automatic fin();
        model_check();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        half();
        fin();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [NR-1:0]   req;
        logic [1:0]      ack;
        logic            tv;
        logic            ale;
        logic [NR-1:0]   grant;
        logic [2*NR-1:0] rack;
        logic            busy;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int gi;
        tbl[0]  = '{4'b0011, 2'b00, 1'b1, 1'b0, 4'b0001, 8'h00, 1'b0};
        tbl[1]  = '{4'b0011, 2'b01, 1'b1, 1'b1, 4'b0001, 8'h01, 1'b1};
        tbl[2]  = '{4'b0010, 2'b01, 1'b0, 1'b1, 4'b0001, 8'h01, 1'b1};
        tbl[3]  = '{4'b0010, 2'b01, 1'b0, 1'b1, 4'b0001, 8'h01, 1'b1};
        tbl[4]  = '{4'b0010, 2'b01, 1'b0, 1'b1, 4'b0001, 8'h01, 1'b1};
        tbl[5]  = '{4'b0010, 2'b00, 1'b1, 1'b0, 4'b0010, 8'h00, 1'b0};
        tbl[6]  = '{4'b0010, 2'b01, 1'b1, 1'b1, 4'b0010, 8'h04, 1'b1};
        tbl[7]  = '{4'b0000, 2'b01, 1'b0, 1'b1, 4'b0000, 8'h00, 1'b0};
        tbl[8]  = '{4'b0001, 2'b00, 1'b1, 1'b0, 4'b0001, 8'h00, 1'b0};
        tbl[9]  = '{4'b0001, 2'b10, 1'b1, 1'b1, 4'b0001, 8'h02, 1'b1};
        tbl[10] = '{4'b0101, 2'b00, 1'b1, 1'b0, 4'b0100, 8'h00, 1'b0};
        tbl[11] = '{4'b0101, 2'b00, 1'b1, 1'b1, 4'b0100, 8'h00, 1'b1};
        tbl[12] = '{4'b0000, 2'b11, 1'b1, 1'b1, 4'b0100, 8'h30, 1'b1};
        tbl[13] = '{4'b1001, 2'b00, 1'b1, 1'b0, 4'b1000, 8'h00, 1'b0};
        tbl[14] = '{4'b0000, 2'b01, 1'b1, 1'b1, 4'b1000, 8'h40, 1'b1};
        tbl[15] = '{4'b0000, 2'b00, 1'b0, 1'b1, 4'b1000, 8'h00, 1'b1};
        tbl[16] = '{4'b0000, 2'b01, 1'b0, 1'b1, 4'b1000, 8'h40, 1'b1};
        tbl[17] = '{4'b0000, 2'b00, 1'b0, 1'b1, 4'b0000, 8'h00, 1'b0};

        // Reset with a quiet bus
        reset         = 1'b1;
        bus.req       = '0;
        bus.pj_ack    = 2'b00;
        bus.req_type  = 16'h8765;          // type of requestor i is i+5
        bus.req_size  = 8'hE4;             // size of requestor i is i
        bus.req_beats = {3'd2, 3'd0, 3'd1, 3'd4};
        @(posedge clk);
        #1;
        step();
        step();
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 18; i++) begin
            bus.req    = tbl[i].req;
            bus.pj_ack = tbl[i].ack;
            half();
            chk($sformatf("tbl%0d_tv", i), bus.pj_tv, tbl[i].tv);
            chk($sformatf("tbl%0d_ale", i), bus.pj_ale, tbl[i].ale);
            chk($sformatf("tbl%0d_grant", i), bus.grant, tbl[i].grant);
            chk($sformatf("tbl%0d_req_ack", i), bus.req_ack, tbl[i].rack);
            chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].busy);
            if (tbl[i].grant != '0) begin
                gi = 0;
                for (int b = 0; b < NR; b++) if (tbl[i].grant[b]) gi = b;
                chk($sformatf("tbl%0d_type", i), bus.pj_type, 32'(gi + 5));
                chk($sformatf("tbl%0d_size", i), bus.pj_size, 32'(gi));
            end
            fin();
        end

        // Error ack on beat 2 of a 4-beat transfer
        bus.req = 4'b0001; bus.pj_ack = 2'b00; step();
        bus.req = 4'b0000; bus.pj_ack = 2'b01;
        half(); chk("err_beat1_ack", bus.req_ack, 8'h01); fin();
        bus.pj_ack = 2'b10;
        half(); chk("err_beat2_ack", bus.req_ack, 8'h02); fin();
        bus.pj_ack = 2'b01;
        half(); chk("err_after_busy", bus.busy, 1'b0); chk("err_after_ack", bus.req_ack, 8'h00); fin();
        bus.pj_ack = 2'b00;

        // Reset in DATA with counter at 2; pointer must return to 0
        bus.req = 4'b0001; step();
        bus.req = 4'b0000; bus.pj_ack = 2'b01; step(); step();
        reset = 1'b1;
        half();
        chk("rst_mid_busy", bus.busy, 1'b0);
        chk("rst_mid_grant", bus.grant, 4'b0000);
        chk("rst_mid_ale", bus.pj_ale, 1'b1);
        chk("rst_mid_req_ack", bus.req_ack, 8'h00);
        fin();
        reset = 1'b0; bus.pj_ack = 2'b00;
        half();
        chk("rst_after_busy", bus.busy, 1'b0);
        chk("rst_after_grant", bus.grant, 4'b0000);
        chk("rst_after_ale", bus.pj_ale, 1'b1);
        fin();
        bus.req = 4'b0011;
        half(); chk("rst_ptr_grant", bus.grant, 4'b0001); fin();
        bus.req = 4'b0000; bus.pj_ack = 2'b01;
        for (int i = 0; i < 4; i++) step();
        bus.pj_ack = 2'b00;
        half(); chk("rst_done_busy", bus.busy, 1'b0); fin();

        // Zero beats behaves as one beat
        bus.req = 4'b0100;
        half(); chk("b0_launch_ale", bus.pj_ale, 1'b0); chk("b0_launch_grant", bus.grant, 4'b0100); fin();
        bus.req = 4'b0000; bus.pj_ack = 2'b01;
        half(); chk("b0_ack_ale", bus.pj_ale, 1'b1); chk("b0_ack_route", bus.req_ack, 8'h10); fin();
        bus.pj_ack = 2'b00;
        half(); chk("b0_idle_busy", bus.busy, 1'b0); chk("b0_idle_ale", bus.pj_ale, 1'b1); fin();

`ifdef BIU_ARB_TIMEOUT_EN
        // Watchdog fires on the TMO-th ack-less cycle
        bus.req = 4'b0001; step();
        bus.req = 4'b0000;
        for (int k = 1; k <= TMO; k++) begin
            half();
            chk($sformatf("tmo_err_c%0d", k), bus.timeout_err, 1'(k == TMO));
            if (k == TMO) chk("tmo_req_ack", bus.req_ack, 8'h02);
            fin();
        end
        half(); chk("tmo_idle_busy", bus.busy, 1'b0); fin();

        // An ack on cycle 5 restarts the count
        bus.req = 4'b0001; step();
        bus.req = 4'b0000;
        for (int k = 1; k <= 5 + TMO; k++) begin
            bus.pj_ack = (k == 5) ? 2'b01 : 2'b00;
            half();
            chk($sformatf("tmo_rst_c%0d", k), bus.timeout_err, 1'(k == 5 + TMO));
            fin();
        end
        bus.pj_ack = 2'b00;
        half(); chk("tmo_rst_idle", bus.busy, 1'b0); fin();
`endif

        // Random phase against the reference model
        for (int c = 0; c < 600; c++) begin
            int a;
            reset         = ($urandom_range(0, 99) == 0);
            bus.req       = reset ? '0 : NR'($urandom);
            bus.req_type  = 16'($urandom);
            bus.req_size  = 8'($urandom);
            bus.req_beats = 12'($urandom);
            a = $urandom_range(0, 9);
            bus.pj_ack = (a <= 5) ? 2'b01 : (a == 6) ? 2'b10 : (a == 7) ? 2'b11 : 2'b00;
            step();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
